// File: rtl/rv32i_fetch_if.sv
// ---------------------------------------------------------------------------
// rv32i_fetch_if
// Instruction-memory bus between the fetch unit and instruction memory.
//   i_stb_o   request strobe, held until the memory acknowledges
//   i_addr_o  32-bit word address of the request
//   i_ack_i   memory acknowledge; i_data_i is valid in the same cycle
//   i_data_i  32-bit instruction word returned by memory
// The master modport is the fetch unit; the slave modport is the memory.
// ---------------------------------------------------------------------------
interface rv32i_fetch_if;
  logic        i_stb_o;
  logic [31:0] i_addr_o;
  logic        i_ack_i;
  logic [31:0] i_data_i;

  modport master (
    output i_stb_o,
    output i_addr_o,
    input  i_ack_i,
    input  i_data_i
  );

  modport slave (
    input  i_stb_o,
    input  i_addr_o,
    output i_ack_i,
    output i_data_i
  );
endinterface

// File: rtl/rv32i_fetch.sv
// ---------------------------------------------------------------------------
// rv32i_fetch
// Single-outstanding-request instruction fetch unit for an RV32I core.
// A one-cycle fetch_en in IDLE starts a fetch at pc_in; the fetched word is
// held for decode until inst_ready_i or flush. Misaligned PCs and bus
// timeouts are reported as flagged instructions instead of bus traffic.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   fetch_en        one-cycle fetch request (honoured only in IDLE)
//   pc_in           PC to fetch from
//   flush           redirect: discard in-flight or held instruction
//   ibus            instruction-memory bus (master side)
//   inst_o          fetched instruction
//   inst_pc_o       PC of inst_o
//   inst_valid_o    inst_o / inst_pc_o / flags valid for decode
//   inst_ready_i    decode accepts the held instruction
//   misaligned_o    instruction-address-misaligned flag
//   bus_err_o       fetch timeout flag
//   busy_o          high in every state except IDLE
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [31:0]          pc_in,
  input  logic                 flush,
  rv32i_fetch_if.master        ibus,
  output logic [31:0]          inst_o,
  output logic [31:0]          inst_pc_o,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic                 misaligned_o,
  output logic                 bus_err_o,
  output logic                 busy_o
);

  // DROP waits out a bus transaction whose result was flushed away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        stb_q, stb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timed_out;

  assign timed_out = (cnt_q == TIMEOUT);

  // State register plus every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      addr_q  <= PC_RESET;
      inst_q  <= 32'h0;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic. Everything holds by default, which is
  // what keeps the strobe/address stable in WAIT and the instruction stable
  // in HOLD.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (fetch_en && !flush) begin
          pc_d = pc_in;
          if (pc_in[1:0] != 2'b00) begin
            // Misaligned PC becomes a flagged instruction with no bus access.
            state_d = HOLD;
            inst_d  = 32'h0;
            valid_d = 1'b1;
            mis_d   = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = WAIT;
            stb_d   = 1'b1;
            addr_d  = pc_in;
            cnt_d   = 8'h0;
          end
        end
      end

      WAIT: begin
        // An ack takes priority over a timeout reached in the same cycle.
        if (ibus.i_ack_i || timed_out) begin
          stb_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
            mis_d   = 1'b0;
            if (ibus.i_ack_i) begin
              inst_d = ibus.i_data_i;
              err_d  = 1'b0;
            end else begin
              inst_d = 32'h0;
              err_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          // The bus transaction cannot be aborted, so keep strobing in DROP.
          if (flush) begin
            state_d = DROP;
          end
        end
      end

      DROP: begin
        if (ibus.i_ack_i || timed_out) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (inst_ready_i || flush) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // busy is registered alongside the state so it tracks the state exactly.
  assign busy_d = (state_d != IDLE);

  assign ibus.i_stb_o  = stb_q;
  assign ibus.i_addr_o = addr_q;
  assign inst_o        = inst_q;
  assign inst_pc_o     = pc_q;
  assign inst_valid_o  = valid_q;
  assign misaligned_o  = mis_q;
  assign bus_err_o     = err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv32i_fetch
// Scoreboard bench for rv32i_fetch. Each fetch request pushes the expected
// decode-side result (instruction, PC, misaligned, bus error) into a queue;
// a monitor pops an entry whenever inst_valid_o rises and checks that the
// presented values stay put for the whole hold period. A memory responder
// acknowledges each strobe after a chosen number of cycles.
// ---------------------------------------------------------------------------
module tb_rv32i_fetch;
  localparam logic [31:0] PC_RST = 32'h0000_0080;
  localparam int          TMO    = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc_in;
  logic        flush;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        busy_o;

  rv32i_fetch_if ibus ();

  rv32i_fetch #(
    .PC_RESET (PC_RST),
    .TIMEOUT  (8'(TMO))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc_in        (pc_in),
    .flush        (flush),
    .ibus         (ibus.master),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   ack_delay  = 0;
  bit   stray_ack  = 1'b0;
  int   stb_cycles = 0;

  // Instruction memory contents: a fixed scramble of the address, with the
  // word at 0x100 pinned to addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: what decode must see for a fetch at pc when the
  // memory acks in strobe cycle 'delay'.
  function automatic exp_t expect_for(input logic [31:0] pc, input int delay);
    exp_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00) begin
      e.inst = 32'h0; e.mis = 1'b1; e.err = 1'b0;
    end else if (delay <= TMO) begin
      e.inst = mem_word(pc); e.mis = 1'b0; e.err = 1'b0;
    end else begin
      e.inst = 32'h0; e.mis = 1'b0; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [65:0] act,
                             input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IDLE while decode randomly stalls and junk fetch_en pulses
  // arrive; busy_o reflects the current state so these are never honoured.
  task automatic waitIdle(input bit random_ready);
    int guard = 0;
    while (busy_o && guard < 200) begin
      if (random_ready) inst_ready_i = 1'($urandom % 2);
      fetch_en = 1'($urandom % 2);
      pc_in    = $urandom;
      tick();
      guard++;
    end
    fetch_en = 1'b0;
    if (guard >= 200) checkOutput("idle_timeout", 66'(busy_o), 66'(0));
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input int delay,
                               input bit push);
    waitIdle(1'b1);
    ack_delay = delay;
    if (push) exp_q.push_back(expect_for(pc, delay));
    pc_in    = pc;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask

  // Memory responder: acks in strobe cycle ack_delay, drives noise on the
  // data lines otherwise, and can inject stray acks.
  initial begin
    ibus.i_ack_i  = 1'b0;
    ibus.i_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      ibus.i_ack_i  = 1'b0;
      ibus.i_data_i = $urandom;
      if (stray_ack) begin
        ibus.i_ack_i = 1'b1;
      end else if (ibus.i_stb_o) begin
        if (stb_cycles == ack_delay) begin
          ibus.i_ack_i  = 1'b1;
          ibus.i_data_i = mem_word(ibus.i_addr_o);
        end
        stb_cycles++;
      end else begin
        stb_cycles = 0;
      end
    end
  end

  // Monitor: pops on each rising inst_valid_o, then checks stability.
  initial begin
    exp_t cur;
    exp_t act;
    bit   prev_valid = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      act = '{inst: inst_o, pc: inst_pc_o, mis: misaligned_o, err: bus_err_o};
      if (inst_valid_o) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", 66'(1), 66'(0));
          end else begin
            cur = exp_q.pop_front();
            checkOutput("sb_inst", act, cur);
          end
        end else begin
          checkOutput("hold_stable", act, cur);
        end
      end
      prev_valid = inst_valid_o;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; fetch_en = 1'b0; pc_in = 32'h0; flush = 1'b0;
    inst_ready_i = 1'b1;
    tick(); tick();
    checkOutput("rst_stb",   66'(ibus.i_stb_o), 66'(0));
    checkOutput("rst_addr",  66'(ibus.i_addr_o), 66'(PC_RST));
    checkOutput("rst_pc",    66'(inst_pc_o), 66'(PC_RST));
    checkOutput("rst_flags", 66'({inst_valid_o, misaligned_o, bus_err_o, busy_o}), 66'(0));
    checkOutput("rst_inst",  66'(inst_o), 66'(0));
    rst = 1'b0;
    tick();

    // Basic fetch with ack in the first strobe cycle: valid two cycles later.
    applyStimulus(32'h100, 0, 1'b1);
    checkOutput("lat_stb",   66'({ibus.i_stb_o, ibus.i_addr_o}), 66'({1'b1, 32'h100}));
    checkOutput("lat_v1",    66'(inst_valid_o), 66'(0));
    tick();
    checkOutput("lat_v2",    66'({inst_valid_o, inst_o, inst_pc_o}),
                66'({1'b1, 32'h0050_0093, 32'h100}));

    // Misaligned PC: flagged instruction next cycle, no strobe.
    applyStimulus(32'h102, 0, 1'b1);
    checkOutput("mis_nostb", 66'({ibus.i_stb_o, inst_valid_o, misaligned_o}), 66'(3'b011));

    // Withheld ack: strobe for TIMEOUT+1 cycles then a bus-error instruction.
    applyStimulus(32'h200, 1000, 1'b1);
    n = 0;
    while (ibus.i_stb_o && n < 20) begin n++; tick(); end
    checkOutput("tmo_stb_cycles", 66'(n), 66'(TMO + 1));
    checkOutput("tmo_flags", 66'({inst_valid_o, bus_err_o}), 66'(2'b11));

    // Flush during WAIT: strobe held through DROP until ack, no instruction.
    applyStimulus(32'h300, 3, 1'b0);
    flush = 1'b1; tick(); tick(); flush = 1'b0;
    n = 2;
    while (ibus.i_stb_o && n < 20) begin n++; tick(); end
    checkOutput("drop_stb_cycles", 66'(n), 66'(4));
    checkOutput("drop_busy", 66'({busy_o, inst_valid_o}), 66'(0));

    // Flush in the same cycle as the ack: data discarded.
    applyStimulus(32'h340, 0, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    checkOutput("flush_ack", 66'({ibus.i_stb_o, busy_o, inst_valid_o}), 66'(0));

    // fetch_en together with flush in IDLE: no request.
    pc_in = 32'h380; fetch_en = 1'b1; flush = 1'b1; tick();
    fetch_en = 1'b0; flush = 1'b0;
    checkOutput("idle_flush", 66'({ibus.i_stb_o, busy_o}), 66'(0));

    // Decode stalls while pc_in and bus data toggle.
    inst_ready_i = 1'b0;
    applyStimulus(32'h400, 1, 1'b1);
    for (int i = 0; i < 7; i++) begin pc_in = $urandom; tick(); end
    inst_ready_i = 1'b1; tick();
    checkOutput("hold_release", 66'(inst_valid_o), 66'(0));

    // Reset in WAIT, then a stray ack afterwards.
    applyStimulus(32'h500, 1000, 1'b0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("wrst_bus",   66'({ibus.i_stb_o, ibus.i_addr_o}), 66'({1'b0, PC_RST}));
    checkOutput("wrst_out",   66'({inst_valid_o, misaligned_o, bus_err_o, busy_o, inst_o}), 66'(0));
    checkOutput("wrst_pc",    66'(inst_pc_o), 66'(PC_RST));
    stray_ack = 1'b1; tick(); tick(); stray_ack = 1'b0; tick();
    checkOutput("late_ack", 66'({ibus.i_stb_o, busy_o, inst_valid_o}), 66'(0));

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom % 4 != 0) pc[1:0] = 2'b00;
      applyStimulus(pc, int'($urandom_range(0, TMO + 2)), 1'b1);
    end
    waitIdle(1'b1);
    inst_ready_i = 1'b1;
    tick(); tick();
    checkOutput("sb_drained", 66'(exp_q.size()), 66'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32i_fetch.md
RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, value of address/PC registers after reset.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum WAIT cycles without ack before bus-timeout is reported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 fetch_en  input  1  single-cycle request to fetch at pc_in; honoured only in IDLE.
REQ-006 pc_in  input  32  next PC from writeback stage.
REQ-007 flush  input  1  redirect (trap entry/mret); discards in-flight or held instruction.
REQ-008 i_stb_o  output  1  instruction-memory request strobe.
REQ-009 i_addr_o  output  32  instruction-memory word address.
REQ-010 i_ack_i  input  1  memory acknowledge; i_data_i valid in the same cycle.
REQ-011 i_data_i  input  32  instruction word from memory.
REQ-012 inst_o  output  32  fetched instruction.
REQ-013 inst_pc_o  output  32  PC of inst_o.
REQ-014 inst_valid_o  output  1  inst_o/inst_pc_o/flags valid for decode.
REQ-015 inst_ready_i  input  1  decode accepts the held instruction.
REQ-016 misaligned_o  output  1  instruction-address-misaligned exception flag, qualified by inst_valid_o.
REQ-017 bus_err_o  output  1  fetch timeout flag, qualified by inst_valid_o.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The block SHALL implement states IDLE, WAIT, HOLD, DROP; all outputs SHALL be registered.
REQ-020 IDLE, fetch_en=1, flush=0, pc_in[1:0]!=0: go HOLD next cycle with misaligned_o=1, inst_o=0, inst_pc_o=pc_in, inst_valid_o=1, no bus request.
REQ-021 IDLE, fetch_en=1, flush=0, pc_in[1:0]==0: next cycle i_stb_o=1, i_addr_o=pc_in, inst_pc_o=pc_in, timeout counter=0, go WAIT.
REQ-022 IDLE, fetch_en and flush both high: flush wins; no request, remain IDLE.
REQ-023 WAIT: i_stb_o and i_addr_o SHALL stay constant until the cycle i_ack_i is sampled high.
REQ-024 WAIT, i_ack_i=1, flush=0: next cycle i_stb_o=0, inst_o=i_data_i, inst_valid_o=1, misaligned_o=0, bus_err_o=0, go HOLD.
REQ-025 Latency: earliest inst_valid_o is 2 cycles after fetch_en (ack in first strobe cycle).
REQ-026 WAIT, no ack: timeout counter (8-bit) SHALL increment each cycle; on reaching TIMEOUT, next cycle i_stb_o=0, bus_err_o=1, inst_o=0, inst_valid_o=1, go HOLD.
REQ-027 WAIT, flush=1 without ack: go DROP; i_stb_o remains high (bus transaction not aborted).
REQ-028 WAIT, flush=1 with ack same cycle: data discarded, i_stb_o=0, go IDLE.
REQ-029 DROP: on ack or timeout, i_stb_o=0, go IDLE; inst_valid_o SHALL stay 0; further flush has no effect.
REQ-030 HOLD: inst_o, inst_pc_o, flags SHALL stay stable while inst_valid_o=1 and inst_ready_i=0.
REQ-031 HOLD, inst_ready_i=1 or flush=1: next cycle inst_valid_o=0, go IDLE; fetch_en ignored that cycle.
REQ-032 fetch_en SHALL be ignored in WAIT, HOLD, DROP.
REQ-033 i_ack_i in IDLE or HOLD SHALL be ignored.
REQ-034 At most one outstanding request at any time.

Reset
REQ-035 When rst=1 at a rising edge: state=IDLE, i_stb_o=0, i_addr_o=PC_RESET, inst_o=0, inst_pc_o=PC_RESET, inst_valid_o=0, misaligned_o=0, bus_err_o=0, busy_o=0, counter=0.
REQ-036 Reset mid-transaction (WAIT/DROP) SHALL drop i_stb_o the next cycle; a late ack after reset SHALL be ignored.

Verification
REQ-037 fetch_en, pc_in=0x100; ack on first strobe cycle with data 0x00500093 -> inst_valid_o=1 two cycles after fetch_en, inst_o=0x00500093, inst_pc_o=0x100.
REQ-038 pc_in=0x102, fetch_en -> no i_stb_o; misaligned_o=1, inst_valid_o=1, inst_pc_o=0x102 next cycle.
REQ-039 Request to 0x200, ack withheld, TIMEOUT=4 -> i_stb_o high 5 cycles, then bus_err_o=1, inst_valid_o=1, i_stb_o=0.
REQ-040 Request to 0x300, flush 1 cycle later, ack 3 cycles later -> i_stb_o held until ack, inst_valid_o never asserts, busy_o falls after ack.
REQ-041 HOLD with inst_ready_i=0 for 5 cycles, pc_in and i_data_i toggling -> inst_o/inst_pc_o unchanged; inst_ready_i=1 -> inst_valid_o=0 next cycle.
REQ-042 rst asserted in WAIT -> all outputs at REQ-035 values next cycle; subsequent ack produces no inst_valid_o.
